// File: rtl/sort_pkg.sv
// Shared types and constants for the sorting blocks and their unpermute stage.
package sort_pkg;

  localparam int DEF_INPUTVALS      = 16;
  localparam int DEF_INPUTBITWIDTHS = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SCATTER = 2'b01,
    ST_CHECK   = 2'b10
  } unpermute_state_t;

  // Position entries carry one extra bit so out-of-range indices stay representable.
  function automatic int calc_posw(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_unpermute_if.sv
// Start/data/status bundle between a sorter-side controller and sort_unpermute.
interface sort_unpermute_if
  import sort_pkg::*;
#(
  parameter int INPUTVALS      = DEF_INPUTVALS,
  parameter int INPUTBITWIDTHS = DEF_INPUTBITWIDTHS
);
  localparam int POSW = calc_posw(INPUTVALS);

  logic                                      unsortstart;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  sorted_in;
  logic [INPUTVALS-1:0][POSW-1:0]            positions_in;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  restored;
  logic                                      busy;
  logic                                      unsortdone;
  logic                                      error;

  modport master (
    output unsortstart, sorted_in, positions_in,
    input  restored, busy, unsortdone, error
  );

  modport slave (
    input  unsortstart, sorted_in, positions_in,
    output restored, busy, unsortdone, error
  );

endinterface

// File: rtl/unpermute_tracker.sv
// Written-slot bitmap: flags out-of-range or already-written positions and
// reports when every slot has been filled.
module unpermute_tracker
  import sort_pkg::*;
#(
  parameter int N    = 4,
  parameter int POSW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            wr_en,
  input  logic [POSW-1:0] pos,
  output logic            fresh,
  output logic            all_written
);
  localparam int IW = idx_width(N);

  logic [N-1:0] written_r;
  logic         in_range_s;

  assign in_range_s  = (pos < POSW'(N));
  assign fresh       = in_range_s & ~written_r[pos[IW-1:0]];
  assign all_written = &written_r;

  // Bitmap of slots already written in the current run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_r <= '0;
    end else if (clear) begin
      written_r <= '0;
    end else if (wr_en) begin
      written_r[pos[IW-1:0]] <= 1'b1;
    end
  end

endmodule

// File: rtl/sort_unpermute.sv
// Scatters a sorted list back to its original order, one element per clock.
// Range/duplicate checking and the CHECK state exist only with SORT_UNPERMUTE_CHECK_EN.
module sort_unpermute
  import sort_pkg::*;
#(
  parameter int INPUTVALS      = DEF_INPUTVALS,
  parameter int INPUTBITWIDTHS = DEF_INPUTBITWIDTHS
) (
  input  logic           clk,
  input  logic           reset,
  sort_unpermute_if.slave bus
);
  localparam int POSW = calc_posw(INPUTVALS);
  localparam int IW   = idx_width(INPUTVALS);
  localparam logic [IW-1:0] LAST_IDX = IW'(INPUTVALS - 1);

  unpermute_state_t state_r, state_nx_s;
  logic [IW-1:0]                             idx_r;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  val_r;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  restored_r;
  logic [INPUTVALS-1:0][POSW-1:0]            pos_r;
  logic done_r, error_r, flag_r;
  logic accept_s, scatter_s, finish_s, illegal_s, last_s;
  logic wr_en_s, bad_s, missing_s;
  logic [POSW-1:0] cur_pos_s;

  assign cur_pos_s = pos_r[idx_r];
  assign last_s    = (idx_r == LAST_IDX);

`ifdef SORT_UNPERMUTE_CHECK_EN
  logic fresh_s, all_written_s;

  unpermute_tracker #(.N(INPUTVALS), .POSW(POSW)) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept_s),
    .wr_en       (wr_en_s),
    .pos         (cur_pos_s),
    .fresh       (fresh_s),
    .all_written (all_written_s)
  );

  assign wr_en_s   = scatter_s & fresh_s;
  assign bad_s     = scatter_s & ~fresh_s;
  assign missing_s = (state_r == ST_CHECK) & ~all_written_s;
`else
  logic in_range_s;

  // Without checking, out-of-range writes vanish and duplicates overwrite.
  assign in_range_s = (cur_pos_s < POSW'(INPUTVALS));
  assign wr_en_s    = scatter_s & in_range_s;
  assign bad_s      = 1'b0;
  assign missing_s  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    scatter_s  = 1'b0;
    finish_s   = 1'b0;
    illegal_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.unsortstart) begin
          accept_s   = 1'b1;
          state_nx_s = ST_SCATTER;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SCATTER: begin
        scatter_s = 1'b1;
        if (last_s) begin
`ifdef SORT_UNPERMUTE_CHECK_EN
          state_nx_s = ST_CHECK;
`else
          finish_s   = 1'b1;
          state_nx_s = ST_IDLE;
`endif
        end else begin
          state_nx_s = ST_SCATTER;
        end
      end
      ST_CHECK: begin
`ifdef SORT_UNPERMUTE_CHECK_EN
        finish_s   = 1'b1;
        state_nx_s = ST_IDLE;
`else
        illegal_s  = 1'b1;
        state_nx_s = ST_IDLE;
`endif
      end
      default: begin
        illegal_s  = 1'b1;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Capture, scatter writes, error accumulation and done/error reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r      <= '0;
      val_r      <= '0;
      pos_r      <= '0;
      restored_r <= '0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      flag_r     <= 1'b0;
    end else if (accept_s) begin
      idx_r      <= '0;
      val_r      <= bus.sorted_in;
      pos_r      <= bus.positions_in;
      restored_r <= '0;
      done_r     <= 1'b0;
      flag_r     <= 1'b0;
    end else begin
      if (scatter_s) begin
        idx_r <= last_s ? '0 : idx_r + IW'(1);
      end
      if (wr_en_s) begin
        restored_r[cur_pos_s[IW-1:0]] <= val_r[idx_r];
      end
      if (bad_s | missing_s) begin
        flag_r <= 1'b1;
      end
      if (finish_s) begin
        done_r  <= 1'b1;
        error_r <= flag_r | bad_s | missing_s;
      end
      if (illegal_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign bus.restored   = restored_r;
  assign bus.busy       = (state_r == ST_SCATTER) || (state_r == ST_CHECK);
  assign bus.unsortdone = done_r;
  assign bus.error      = error_r | illegal_s;

endmodule

// File: tb/tb_sort_unpermute.sv
// Directed scoreboard bench for sort_unpermute at INPUTVALS=4, INPUTBITWIDTHS=8.
module tb_sort_unpermute;
  import sort_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = calc_posw(N);
`ifdef SORT_UNPERMUTE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LAT = CHK ? N + 2 : N + 1;

  typedef logic [N-1:0][W-1:0]  val_t;
  typedef logic [N-1:0][PW-1:0] pos_t;
  typedef struct packed {
    val_t restored;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sort_unpermute_if #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) dut_if ();

  sort_unpermute #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  function automatic val_t mk_val(input int a0, input int a1, input int a2, input int a3);
    val_t v;
    v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3);
    return v;
  endfunction

  function automatic pos_t mk_pos(input int a0, input int a1, input int a2, input int a3);
    pos_t p;
    p[0] = PW'(a0); p[1] = PW'(a1); p[2] = PW'(a2); p[3] = PW'(a3);
    return p;
  endfunction

  // Reference inverse permutation built straight from the operation description.
  function automatic exp_t model(input val_t v, input pos_t p);
    exp_t         e;
    logic [N-1:0] w;
    logic [1:0]   q;
    e.restored = '0;
    e.err      = 1'b0;
    w          = '0;
    for (int k = 0; k < N; k++) begin
      q = p[k][1:0];
      if ((p[k] < PW'(N)) && !(CHK && w[q])) begin
        e.restored[q] = v[k];
        w[q]          = 1'b1;
      end else if (CHK) begin
        e.err = 1'b1;
      end
    end
    if (CHK && (w != 4'b1111)) e.err = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one start pulse (cycle 0); leaves the bench #1 into cycle 1.
  task automatic start_run(input val_t v, input pos_t p, input bit push);
    dut_if.sorted_in    = v;
    dut_if.positions_in = p;
    dut_if.unsortstart  = 1'b1;
    if (push) sb_q.push_back(model(v, p));
    @(posedge clk); #1;
    dut_if.unsortstart  = 1'b0;
    dut_if.sorted_in    = val_t'($urandom);
    dut_if.positions_in = pos_t'($urandom);
  endtask

  task automatic wait_done(input int c0, input int inject_at, input string tag);
    int   c;
    int   busy_bad;
    exp_t e;
    c = c0;
    busy_bad = 0;
    while ((dut_if.unsortdone !== 1'b1) && (c <= LAT + 4)) begin
      if (dut_if.busy !== 1'b1) busy_bad++;
      if (c == inject_at) begin
        dut_if.sorted_in    = mk_val(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        dut_if.positions_in = mk_pos(3, 2, 1, 0);
        dut_if.unsortstart  = 1'b1;
      end
      @(posedge clk); #1;
      if (c == inject_at) dut_if.unsortstart = 1'b0;
      c++;
    end
    chk({tag, "_latency"}, 64'(c), 64'(LAT));
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, "_busy_done"}, 64'(dut_if.busy), 64'd0);
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s_scoreboard: observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_restored"}, 64'(dut_if.restored), 64'(e.restored));
      chk({tag, "_error"}, 64'(dut_if.error), 64'(e.err));
    end
  endtask

  initial begin
    val_t vb, vn;
    pos_t pb, pd, po, pn;
    vb = mk_val(3, 5, 9, 12);
    pb = mk_pos(2, 0, 3, 1);
    pd = mk_pos(1, 1, 0, 3);
    po = mk_pos(0, 1, 2, 5);
    vn = mk_val(7, 1, 4, 2);
    pn = mk_pos(3, 2, 1, 0);

    reset = 1'b1;
    dut_if.unsortstart  = 1'b0;
    dut_if.sorted_in    = '0;
    dut_if.positions_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_restored", 64'(dut_if.restored), 64'd0);
    chk("rst_busy", 64'(dut_if.busy), 64'd0);
    chk("rst_done", 64'(dut_if.unsortdone), 64'd0);
    chk("rst_error", 64'(dut_if.error), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic inverse, also against the literal expected list.
    start_run(vb, pb, 1'b1);
    wait_done(1, 0, "basic");
    chk("basic_literal", 64'(dut_if.restored), 64'(mk_val(5, 12, 3, 9)));

    start_run(vb, pd, 1'b1);
    wait_done(1, 0, "dup");
    chk("dup_slot2", 64'(dut_if.restored[2]), 64'd0);
    chk("dup_slot1", 64'(dut_if.restored[1]), CHK ? 64'd3 : 64'd5);

    start_run(vb, po, 1'b1);
    wait_done(1, 0, "oor");
    chk("oor_slot3", 64'(dut_if.restored[3]), 64'd0);

    // Second start at cycle 3 lands mid-run and must be ignored.
    start_run(vb, pb, 1'b1);
    wait_done(1, 3, "busystart");
    repeat (2) @(posedge clk);
    #1;
    chk("busystart_idle", 64'(dut_if.busy), 64'd0);
    start_run(vn, pn, 1'b1);
    wait_done(1, 0, "newrun");

    // Reset during cycle 3 aborts the run.
    start_run(vb, pd, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_restored", 64'(dut_if.restored), 64'd0);
    chk("midrst_busy", 64'(dut_if.busy), 64'd0);
    chk("midrst_done", 64'(dut_if.unsortdone), 64'd0);
    chk("midrst_error", 64'(dut_if.error), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    start_run(vb, pb, 1'b1);
    wait_done(1, 0, "afterrst");

    // Start held high: second run begins in the first IDLE cycle after done.
    dut_if.sorted_in    = vn;
    dut_if.positions_in = pn;
    dut_if.unsortstart  = 1'b1;
    sb_q.push_back(model(vn, pn));
    sb_q.push_back(model(vn, pn));
    @(posedge clk); #1;
    wait_done(1, 0, "held1");
    @(posedge clk); #1;
    chk("held_done_clr", 64'(dut_if.unsortdone), 64'd0);
    chk("held_busy", 64'(dut_if.busy), 64'd1);
    dut_if.unsortstart = 1'b0;
    wait_done(1, 0, "held2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
